product_accumulator: RTL and testbench

- Downstream consumer of the 32x32 signed registered multiplier's 64-bit product.
- Sums a programmed number of signed products (dot-product / MAC tail) into a guarded accumulator, then presents the result over a valid/ready handshake.
- Accepts one product per cycle.
- Shares the multiplier's clk/en domain, so a registered product stream feeds it directly.

---
 rtl/mulx_pkg.sv | 21 ++
 rtl/product_accumulator_if.sv | 27 ++
 rtl/acc_saturate.sv | 26 ++
 rtl/product_accumulator.sv | 120 ++++++++++++
 tb/tb_product_accumulator.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mulx_pkg.sv
// Shared widths, FSM states and 64-bit clamp limits for the
// multiplier / product-accumulator datapath.
package mulx_pkg;

  localparam int PROD_W  = 64;
  localparam int GUARD_W = 8;
  localparam int ACC_W   = PROD_W + GUARD_W;
  localparam int LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [PROD_W-1:0] P_MAX =
    {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic [PROD_W-1:0] P_MIN =
    {1'b1, {(PROD_W-1){1'b0}}};

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out valid-ready bundle of the
// product accumulator.
interface product_accumulator_if;
  import mulx_pkg::*;

  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [PROD_W-1:0] res64;
  logic              acc_sat;

  modport master (
    output prod_valid, prod, acc_ready,
    input  prod_ready, acc_valid,
    input  acc_out, res64, acc_sat
  );

  modport slave (
    input  prod_valid, prod, acc_ready,
    output prod_ready, acc_valid,
    output acc_out, res64, acc_sat
  );

endinterface

// File: rtl/acc_saturate.sv
// Clamps the full-precision accumulator to signed 64 bits
// and flags when the clamp changed the value.
module acc_saturate
  import mulx_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  output logic [PROD_W-1:0] res,
  output logic              sat
);

  logic [GUARD_W:0] top;
  logic             ovf;

  // fits in 64 bits only if guard bits copy bit 63
  assign top = acc[ACC_W-1:PROD_W-1];
  assign ovf = ~((&top) | ~(|top));

  always_comb begin
    res = acc[PROD_W-1:0];
    sat = ovf;
    if (ovf) begin
      res = acc[ACC_W-1] ? P_MIN : P_MAX;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums len signed products into a guarded accumulator.
// PRODUCT_ACCUMULATOR_SAT_EN: clamp res64 instead of truncating.
module product_accumulator
  import mulx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  product_accumulator_if.slave bus
);

  state_t            state;
  state_t            state_d;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  out_d;
  logic [ACC_W-1:0]  out_q;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_q;
  logic [PROD_W-1:0] res_d;
  logic [PROD_W-1:0] res_q;
  logic              sat_d;
  logic              sat_q;
  logic              xfer;
  logic              load;
  logic              take_start;

  assign acc_sum = acc +
    {{GUARD_W{bus.prod[PROD_W-1]}}, bus.prod};

  always_comb begin
    state_d    = state;
    acc_d      = acc;
    out_d      = acc_sum;
    xfer       = 1'b0;
    load       = 1'b0;
    take_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          acc_d      = '0;
          if (len != '0) begin
            state_d = ACCUM;
          end else begin
            state_d = DONE;
            out_d   = '0;
            load    = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (bus.prod_valid) begin
          xfer  = 1'b1;
          acc_d = acc_sum;
          if (count == len_q - LEN_W'(1)) begin
            state_d = DONE;
            load    = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.acc_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  acc_saturate u_sat (
    .acc (out_d),
    .res (res_d),
    .sat (sat_d)
  );
`else
  assign res_d = out_d[PROD_W-1:0];
  assign sat_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      out_q <= '0;
      res_q <= '0;
      sat_q <= 1'b0;
    end else if (en) begin
      state <= state_d;
      acc   <= acc_d;
      if (take_start) begin
        count <= '0;
        len_q <= len;
      end else if (xfer) begin
        count <= count + LEN_W'(1);
      end
      // result registers change only when a sum completes
      if (load) begin
        out_q <= out_d;
        res_q <= res_d;
        sat_q <= sat_d;
      end
    end
  end

  assign bus.prod_ready = (state == ACCUM);
  assign bus.acc_valid  = (state == DONE);
  assign bus.acc_out    = out_q;
  assign bus.res64      = res_q;
  assign bus.acc_sat    = sat_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized + directed bench for product_accumulator
// against a per-transaction behavioural model.
module tb_product_accumulator;
  import mulx_pkg::*;

  logic             clk;
  logic             reset;
  logic             en;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;

  product_accumulator_if bus ();

  product_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .len   (len),
    .busy  (busy),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic signed [71:0] HI = 72'sh00_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [71:0] LO = -HI - 72'sd1;

  // model: 0 idle, 1 collecting, 2 result held
  int               m_phase;
  int               m_left;
  logic signed [71:0] m_sum;
  logic signed [71:0] m_out;
  logic [63:0]      m_res;
  logic             m_sat;

  function automatic logic signed [71:0] sx(input logic [63:0] p);
    logic signed [63:0] s;
    s = p;
    return 72'(s);
  endfunction

  function automatic logic [63:0] res_of(input logic signed [71:0] s);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    if (s > HI) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (s < LO) return 64'h8000_0000_0000_0000;
`endif
    return s[63:0];
  endfunction

  function automatic logic sat_of(input logic signed [71:0] s);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    return (s > HI) || (s < LO);
`else
    return (s != s) || 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_phase <= 0;
      m_left  <= 0;
      m_sum   <= '0;
      m_out   <= '0;
      m_res   <= '0;
      m_sat   <= 1'b0;
    end else if (en) begin
      case (m_phase)
        0: if (start) begin
          m_sum <= '0;
          if (len != 0) begin
            m_left  <= int'(len);
            m_phase <= 1;
          end else begin
            m_out   <= '0;
            m_res   <= '0;
            m_sat   <= 1'b0;
            m_phase <= 2;
          end
        end
        1: if (bus.prod_valid) begin
          m_sum  <= m_sum + sx(bus.prod);
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_out   <= m_sum + sx(bus.prod);
            m_res   <= res_of(m_sum + sx(bus.prod));
            m_sat   <= sat_of(m_sum + sx(bus.prod));
            m_phase <= 2;
          end
        end
        default: if (bus.acc_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("prod_ready", 72'(bus.prod_ready), 72'(m_phase == 1));
    chk("acc_valid", 72'(bus.acc_valid), 72'(m_phase == 2));
    chk("busy", 72'(busy), 72'(m_phase != 0));
    chk("acc_out", bus.acc_out, m_out);
    chk("res64", 72'(bus.res64), 72'(m_res));
    chk("acc_sat", 72'(bus.acc_sat), 72'(m_sat));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] p);
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    cyc();
    bus.prod_valid = 1'b0;
  endtask

  task automatic take();
    bus.acc_ready = 1'b1;
    cyc();
    bus.acc_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    en             = 1'b1;
    start          = 1'b0;
    len            = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.acc_ready  = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_out", bus.acc_out, 72'd0);
    reset = 1'b1;
    cyc();

    // four back-to-back products
    do_start(4);
    send(-64'sd35);
    send(64'sd6);
    send(64'sd48);
    send(-64'sd45);
    chk("d1_valid", 72'(bus.acc_valid), 72'd1);
    chk("d1_out", bus.acc_out, -72'sd26);
    chk("d1_model", m_out, -72'sd26);
    chk("d1_res", 72'(bus.res64), 72'(64'hFFFF_FFFF_FFFF_FFE6));
    chk("d1_sat", 72'(bus.acc_sat), 72'd0);
    take();

    // zero-length request
    do_start(0);
    chk("d2_valid", 72'(bus.acc_valid), 72'd1);
    chk("d2_out", bus.acc_out, 72'd0);
    chk("d2_pready", 72'(bus.prod_ready), 72'd0);
    take();

    // gaps and clock-enable stall mid-stream
    do_start(3);
    send(64'sd10);
    cyc();
    en             = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 64'sd99;
    cyc();
    cyc();
    bus.prod_valid = 1'b0;
    en             = 1'b1;
    chk("d3_stall", 72'(busy), 72'd1);
    send(64'sd0);
    cyc();
    send(64'sd24);
    chk("d3_out", bus.acc_out, 72'sd34);
    chk("d3_model", m_out, 72'sd34);

    // held result while downstream stalls, start ignored
    take();
    do_start(2);
    send(64'sd1);
    send(64'sd2);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 8'd5;
      cyc();
      chk("d4_hold", bus.acc_out, 72'd3);
      chk("d4_pready", 72'(bus.prod_ready), 72'd0);
      chk("d4_valid", 72'(bus.acc_valid), 72'd1);
    end
    start = 1'b0;
    take();
    chk("d4_busy", 72'(busy), 72'd0);
    chk("d4_idle", 72'(bus.acc_valid), 72'd0);

    // largest positive product twice
    do_start(2);
    send(64'h7FFF_FFFF_FFFF_FFFF);
    send(64'h7FFF_FFFF_FFFF_FFFF);
    chk("d5_out", bus.acc_out, 72'h00_FFFF_FFFF_FFFF_FFFE);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    chk("d5_res", 72'(bus.res64), 72'(64'h7FFF_FFFF_FFFF_FFFF));
    chk("d5_sat", 72'(bus.acc_sat), 72'd1);
`else
    chk("d5_res", 72'(bus.res64), 72'(64'hFFFF_FFFF_FFFF_FFFE));
    chk("d5_sat", 72'(bus.acc_sat), 72'd0);
`endif
    take();

    // reset aborts a partial sum
    do_start(4);
    send(64'sd5);
    send(64'sd6);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("d6_busy", 72'(busy), 72'd0);
    chk("d6_out", bus.acc_out, 72'd0);
    chk("d6_pready", 72'(bus.prod_ready), 72'd0);
    do_start(1);
    send(64'sd7);
    chk("d6_out7", bus.acc_out, 72'sd7);

    // free-running random traffic, model tracks every cycle
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 399) != 0);
      en             = ($urandom_range(0, 7) != 0);
      start          = ($urandom_range(0, 3) == 0);
      len            = ($urandom_range(0, 15) == 0) ?
                       LEN_W'($urandom_range(0, 255)) :
                       LEN_W'($urandom_range(0, 6));
      bus.prod_valid = ($urandom_range(0, 2) != 0);
      bus.acc_ready  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: bus.prod = {$urandom, $urandom};
        1: bus.prod = $urandom_range(0, 1) ?
                      64'h7FFF_FFFF_FFFF_FFFF :
                      64'h8000_0000_0000_0000;
        default: bus.prod = 64'($signed($urandom_range(0, 2000)) - 1000);
      endcase
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
